// File: rtl/cla_serial_add_ctrl.sv
// rtl/cla_serial_add_ctrl.sv - WIDTH-bit add/sub sequenced over one 4-bit CLA slice

// Combinational 4-bit carry-lookahead adder slice.
module CLA_Add4_gen (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cIn,
  output logic [3:0] s,
  output logic       cOut
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Lookahead carries computed directly from generate/propagate terms.
  always_comb begin
    c[0] = cIn;
    c[1] = g[0] | (p[0] & cIn);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cIn);
    cOut = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cIn);
  end

  assign s = p ^ c;

endmodule

// Controller: latches operands on start, feeds one nibble per cycle LSB first,
// ripples the carry through c_reg and assembles the result in r_sh.
module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // WIDTH must be a multiple of 4 and at least 8.
  localparam int N     = WIDTH / 4;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the N-1 low nibbles already produced; the final nibble comes
  // straight from the slice on the last edge.
  logic [WIDTH-5:0] r_sh;
  logic [WIDTH-1:0] r_cat;
  logic             c_reg;
  logic             msb_a;
  logic             msb_b;
  logic [CNT_W-1:0] cnt;

  logic [3:0] slice_s;
  logic       slice_cout;
  logic       accept;
  logic       last;
  logic [WIDTH-1:0] b_eff;

  CLA_Add4_gen u_slice (
    .x    (a_sh[3:0]),
    .y    (b_sh[3:0]),
    .cIn  (c_reg),
    .s    (slice_s),
    .cOut (slice_cout)
  );

  // Start is honoured in IDLE and DONE only; a start on the closing RUN edge is dropped.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);
  assign b_eff  = sub ? ~b : b;
  assign r_cat  = {slice_s, r_sh};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; DONE chains straight back into RUN when start is held.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = start ? RUN : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand latch, per-nibble shift/carry ripple and final result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      c_reg <= 1'b0;
      msb_a <= 1'b0;
      msb_b <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_eff;
      c_reg <= sub ? 1'b1 : cin;
      msb_a <= a[WIDTH-1];
      msb_b <= b_eff[WIDTH-1];
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= {4'b0000, a_sh[WIDTH-1:4]};
      b_sh  <= {4'b0000, b_sh[WIDTH-1:4]};
      r_sh  <= r_cat[WIDTH-1:4];
      c_reg <= slice_cout;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= r_cat;
        cout <= slice_cout;
        ovf  <= (msb_a == msb_b) && (slice_s[3] != msb_a);
      end
    end
  end

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// tb/tb_cla_serial_add_ctrl.sv - directed bench for cla_serial_add_ctrl
module tb_cla_serial_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks;
  int errors;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
  } op_t;

  vec_t vecs[8];
  op_t  ops[15];

  cla_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input op_t o);
    logic [15:0] bb;
    logic [16:0] t;
    logic        v;
    bb = o.sub ? ~o.b : o.b;
    t  = {1'b0, o.a} + {1'b0, bb} + {16'd0, (o.sub ? 1'b1 : o.cin)};
    v  = (o.a[15] == bb[15]) && (t[15] != o.a[15]);
    return {v, t[16], t[15:0]};
  endfunction

  // Called just after a negedge; issues one op and checks timing and result.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    int busy_cnt;
    sub   = v.sub;
    a     = v.a;
    b     = v.b;
    cin   = v.cin;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    sub   = ~v.sub;
    a     = ~v.a;
    b     = ~v.b;
    cin   = ~v.cin;
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 10) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " busy_cycles"}, busy_cnt, 4);
    chk({tag, " sum"}, sum, v.e_sum);
    chk({tag, " cout"}, cout, v.e_cout);
    chk({tag, " ovf"}, ovf, v.e_ovf);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 1'b0);
    chk({tag, " sum_hold"}, sum, v.e_sum);
  endtask

  initial begin
    logic [17:0] exp;
    logic        saw_done;
    int          k;
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h000F, 16'h0001, 1'b1, 16'h0011, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      ops[i].sub = i[0];
      ops[i].cin = i[1];
      ops[i].a   = 16'(i * 16'h1357 + 16'h0123);
      ops[i].b   = 16'(i * 16'h2468 + 16'h0F0F);
    end

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset sum", sum, 16'h0);
    chk("reset cout", cout, 1'b0);
    chk("reset ovf", ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high, operands changing every cycle: accept at cycles 0, 5, 10.
    for (int i = 0; i < 15; i++) begin
      start = 1'b1;
      sub   = ops[i].sub;
      a     = ops[i].a;
      b     = ops[i].b;
      cin   = ops[i].cin;
      @(posedge clk);
      @(negedge clk);
      if (i % 5 == 4) begin
        exp = model(ops[i - 4]);
        chk($sformatf("b2b%0d done", i), done, 1'b1);
        chk($sformatf("b2b%0d sum", i), sum, exp[15:0]);
        chk($sformatf("b2b%0d cout", i), cout, exp[16]);
        chk($sformatf("b2b%0d ovf", i), ovf, exp[17]);
      end else begin
        chk($sformatf("b2b%0d done", i), done, 1'b0);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b idle busy", busy, 1'b0);

    // Reset during the 2nd RUN cycle aborts the operation.
    sub   = 1'b0;
    a     = 16'h1111;
    b     = 16'h2222;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort sum", sum, 16'h0);
    chk("abort cout", cout, 1'b0);
    chk("abort ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    k = 0;
    while (k < 8) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
      k++;
    end
    chk("abort no_done", saw_done, 1'b0);
    run_op(vecs[0], "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
